// File: rtl/p_output_router_strait.sv
// p_output_router_strait: 2-entry in-order output buffer steering P results to the bottom or right neighbour.
// Defining STRAIT_MISR_EN adds a 32-bit MISR signature over every popped word.
module p_output_router_strait #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   in_p,
    input  logic          in_sel,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [31:0]   to_bottom,
    output logic          bottom_valid,
    input  logic          bottom_ready,
    output logic [31:0]   to_right,
    output logic          right_valid,
    input  logic          right_ready,
    output logic [CW-1:0] pop_count,
    input  logic          misr_clr,
    output logic [31:0]   misr_sig
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t      state, state_next;
    logic [31:0] head_data, tail_data;
    logic        head_sel, tail_sel;
    logic        push, pop, load_head, shift_head, load_tail;

    // Only the head's selected ready matters; a blocked head stalls everything behind it.
    always_comb begin
        in_ready   = state != FULL;
        push       = in_valid && in_ready;
        pop        = (state != EMPTY) && (head_sel ? right_ready : bottom_ready);
        state_next = state;
        load_head  = 1'b0;
        shift_head = 1'b0;
        load_tail  = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_next = ONE;
                    load_head  = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_head = 1'b1;
                end else if (push) begin
                    state_next = FULL;
                    load_tail  = 1'b1;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_next = ONE;
                    shift_head = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            head_data <= '0;
            head_sel  <= 1'b0;
            tail_data <= '0;
            tail_sel  <= 1'b0;
            pop_count <= '0;
        end else begin
            state <= state_next;
            if (load_head) begin
                head_data <= in_p;
                head_sel  <= in_sel;
            end else if (shift_head) begin
                head_data <= tail_data;
                head_sel  <= tail_sel;
            end
            if (load_tail) begin
                tail_data <= in_p;
                tail_sel  <= in_sel;
            end
            if (pop)
                pop_count <= pop_count + CW'(1);
        end
    end

    always_comb begin
        bottom_valid = (state != EMPTY) && !head_sel;
        right_valid  = (state != EMPTY) && head_sel;
        to_bottom    = bottom_valid ? head_data : '0;
        to_right     = right_valid ? head_data : '0;
    end

`ifdef STRAIT_MISR_EN
    logic [31:0] misr;
    logic        misr_fb;

    assign misr_fb  = misr[31] ^ misr[21] ^ misr[1] ^ misr[0];
    assign misr_sig = misr;

    // Clear wins over a simultaneous pop so a test can start from a known seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misr <= '0;
        else if (misr_clr)
            misr <= '0;
        else if (pop)
            misr <= {misr[30:0], misr_fb} ^ head_data;
    end
`else
    logic unused_misr_clr;

    assign unused_misr_clr = misr_clr;
    assign misr_sig        = '0;
`endif

endmodule

// File: tb/tb_p_output_router_strait.sv
// tb_p_output_router_strait: scoreboard bench for the STRAIT output router (CW=4 so wrap is reachable).
module tb_p_output_router_strait;
    localparam int CW = 4;

    logic          clk, rst_n;
    logic [31:0]   in_p;
    logic          in_sel, in_valid, in_ready;
    logic [31:0]   to_bottom, to_right, misr_sig;
    logic          bottom_valid, bottom_ready, right_valid, right_ready, misr_clr;
    logic [CW-1:0] pop_count;

    logic [32:0] q[$];
    int n_checks = 0;
    int n_fail = 0;

    p_output_router_strait #(.CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_p(in_p), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready), .to_bottom(to_bottom), .bottom_valid(bottom_valid),
        .bottom_ready(bottom_ready), .to_right(to_right), .right_valid(right_valid),
        .right_ready(right_ready), .pop_count(pop_count), .misr_clr(misr_clr), .misr_sig(misr_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output-side scoreboard: every completed transfer must match the oldest pushed entry.
    always @(negedge clk) begin
        if (rst_n && (bottom_valid || right_valid)) begin
            n_checks++;
            if (bottom_valid && right_valid) begin
                n_fail++;
                $display("FAIL both_valid: bottom_valid=%b right_valid=%b, required one-hot", bottom_valid, right_valid);
            end
            n_checks++;
            if ((right_valid ? to_bottom : to_right) !== 32'h0) begin
                n_fail++;
                $display("FAIL idle_port_zero: to_bottom=%h to_right=%h, required unselected port 0", to_bottom, to_right);
            end
            if ((bottom_valid && bottom_ready) || (right_valid && right_ready)) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_xfer: sel=%b data=%h, required no transfer", right_valid, right_valid ? to_right : to_bottom);
                end else begin
                    logic [32:0] exp_e, obs_e;
                    exp_e = q.pop_front();
                    obs_e = right_valid ? {1'b1, to_right} : {1'b0, to_bottom};
                    if (obs_e !== exp_e) begin
                        n_fail++;
                        $display("FAIL xfer: got sel=%b data=%h, required sel=%b data=%h", obs_e[32], obs_e[31:0], exp_e[32], exp_e[31:0]);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        misr_clr = 1'b0;
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic [31:0] d, input logic s);
        int waited = 0;
        in_p = d;
        in_sel = s;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL push_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
        end else begin
            q.push_back({s, d});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int waited = 0;
        while (q.size() != 0 && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d entries left, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bottom_valid, right_valid, in_ready} !== 3'b001 || to_bottom !== 32'h0 || to_right !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: bv=%b rv=%b ir=%b tb=%h tr=%h, required 0 0 1 0 0", bottom_valid, right_valid, in_ready, to_bottom, to_right);
        end
        n_checks++;
        if (pop_count !== 4'd0 || misr_sig !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_regs: pop_count=%0d misr_sig=%h, required 0 0", pop_count, misr_sig);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bottom_valid !== 1'b0 || right_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_idle: bv=%b rv=%b ir=%b, required 0 0 1", bottom_valid, right_valid, in_ready);
        end
    endtask

    task automatic test_basic();
        do_reset();
        bottom_ready = 1'b1;
        right_ready = 1'b1;
        drive(32'hAAAA_AAAA, 1'b0);
        n_checks++;
        if (bottom_valid !== 1'b1 || to_bottom !== 32'hAAAA_AAAA || right_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_first: bv=%b tb=%h rv=%b ir=%b, required 1 aaaaaaaa 0 1", bottom_valid, to_bottom, right_valid, in_ready);
        end
        drive(32'h5555_5555, 1'b1);
        n_checks++;
        if (right_valid !== 1'b1 || to_right !== 32'h5555_5555 || bottom_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_second: rv=%b tr=%h bv=%b ir=%b, required 1 55555555 0 1", right_valid, to_right, bottom_valid, in_ready);
        end
        drain("basic");
        n_checks++;
        if (pop_count !== 4'd2) begin
            n_fail++;
            $display("FAIL basic_count: pop_count=%0d, required 2", pop_count);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bottom_ready = 1'b0;
        right_ready = 1'b1;
        drive(32'd1, 1'b0);
        drive(32'd2, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: in_ready=%b, required 0", in_ready);
        end
        in_p = 32'd3;
        in_sel = 1'b0;
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (in_ready !== 1'b0 || to_bottom !== 32'd1 || pop_count !== 4'd0) begin
            n_fail++;
            $display("FAIL bp_hold: ir=%b tb=%h pop_count=%0d, required 0 1 0", in_ready, to_bottom, pop_count);
        end
        bottom_ready = 1'b1;
        drive(32'd3, 1'b0);
        drain("bp");
        n_checks++;
        if (pop_count !== 4'd3) begin
            n_fail++;
            $display("FAIL bp_count: pop_count=%0d, required 3", pop_count);
        end
    endtask

    task automatic test_head_of_line();
        do_reset();
        bottom_ready = 1'b0;
        right_ready = 1'b1;
        drive(32'h0000_0011, 1'b0);
        drive(32'h0000_0022, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (right_valid !== 1'b0 || to_right !== 32'h0 || bottom_valid !== 1'b1 || to_bottom !== 32'h11) begin
                n_fail++;
                $display("FAIL hol_blocked: rv=%b tr=%h bv=%b tb=%h, required 0 0 1 11", right_valid, to_right, bottom_valid, to_bottom);
            end
        end
        @(posedge clk); #1;
        bottom_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (right_valid !== 1'b1 || to_right !== 32'h22 || bottom_valid !== 1'b0 || to_bottom !== 32'h0) begin
            n_fail++;
            $display("FAIL hol_release: rv=%b tr=%h bv=%b tb=%h, required 1 22 0 0", right_valid, to_right, bottom_valid, to_bottom);
        end
        drain("hol");
    endtask

    task automatic test_wrap();
        do_reset();
        bottom_ready = 1'b1;
        right_ready = 1'b1;
        for (int i = 0; i < 15; i++) drive(32'h100 + i, i[0]);
        drain("wrap15");
        n_checks++;
        if (pop_count !== 4'd15) begin
            n_fail++;
            $display("FAIL wrap_15: pop_count=%0d, required 15", pop_count);
        end
        drive(32'hDEAD_0016, 1'b1);
        drain("wrap16");
        n_checks++;
        if (pop_count !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_16: pop_count=%0d, required 0", pop_count);
        end
        drive(32'hDEAD_0017, 1'b0);
        drain("wrap17");
        n_checks++;
        if (pop_count !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap_17: pop_count=%0d, required 1", pop_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bottom_ready = 1'b1;
        right_ready = 1'b1;
        drive(32'h7, 1'b0);
        drain("rmid_pre");
        bottom_ready = 1'b0;
        right_ready = 1'b0;
        drive(32'hCAFE_0001, 1'b0);
        drive(32'hCAFE_0002, 1'b1);
        n_checks++;
        if (in_ready !== 1'b0 || pop_count !== 4'd1) begin
            n_fail++;
            $display("FAIL rmid_full: ir=%b pop_count=%0d, required 0 1", in_ready, pop_count);
        end
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        n_checks++;
        if ({bottom_valid, right_valid, in_ready} !== 3'b001 || to_bottom !== 32'h0 || to_right !== 32'h0 || pop_count !== 4'd0) begin
            n_fail++;
            $display("FAIL rmid_async: bv=%b rv=%b ir=%b tb=%h tr=%h pc=%0d, required 0 0 1 0 0 0", bottom_valid, right_valid, in_ready, to_bottom, to_right, pop_count);
        end
        rst_n = 1'b1;
        bottom_ready = 1'b1;
        right_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (bottom_valid !== 1'b0 || right_valid !== 1'b0 || pop_count !== 4'd0) begin
            n_fail++;
            $display("FAIL rmid_stale: bv=%b rv=%b pop_count=%0d, required 0 0 0", bottom_valid, right_valid, pop_count);
        end
    endtask

    task automatic test_misr();
        logic [31:0] exp1, exp2;
`ifdef STRAIT_MISR_EN
        exp1 = 32'hAAAA_AAAA;
`else
        exp1 = 32'h0;
`endif
        exp2 = 32'h0;
        do_reset();
        bottom_ready = 1'b1;
        right_ready = 1'b1;
        drive(32'h1234_5678, 1'b1);
        drain("misr_pre");
        misr_clr = 1'b1;
        @(posedge clk); #1;
        misr_clr = 1'b0;
        n_checks++;
        if (misr_sig !== 32'h0) begin
            n_fail++;
            $display("FAIL misr_clear: misr_sig=%h, required 00000000", misr_sig);
        end
        drive(32'hAAAA_AAAA, 1'b0);
        drain("misr1");
        n_checks++;
        if (misr_sig !== exp1) begin
            n_fail++;
            $display("FAIL misr_pop1: misr_sig=%h, required %h", misr_sig, exp1);
        end
        drive(32'h5555_5555, 1'b1);
        drain("misr2");
        n_checks++;
        if (misr_sig !== exp2) begin
            n_fail++;
            $display("FAIL misr_pop2: misr_sig=%h, required %h", misr_sig, exp2);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_p = '0;
        in_sel = 1'b0;
        in_valid = 1'b0;
        bottom_ready = 1'b1;
        right_ready = 1'b1;
        misr_clr = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_head_of_line();
        test_wrap();
        test_reset_mid();
        test_misr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
